stack_unit: RTL and testbench

STACK_UNIT -- requirements
Module: stack_unit

---
 rtl/stack_pkg.sv | 23 ++
 rtl/stack_ram.sv | 22 ++
 rtl/stack_unit.sv | 139 +++++++++++++
 tb/tb_stack_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types and sizes for the hardware call/data stack.
package stack_pkg;
  localparam int SP_W   = 8;
  localparam int DATA_W = 10;
  localparam int DEPTH  = 256;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic is_write(input op_e op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction
endpackage

// File: rtl/stack_ram.sv
// 256x10 stack storage: synchronous write, registered read with enable.
module stack_ram
  import stack_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [SP_W-1:0]   addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read register only loads on re, so the popped word holds through RESP.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/stack_unit.sv
// Request/response stack engine (PUSH/POP/CALL/RET) over a full-descending stack.
// Define STACK_GUARD_EN to add the depth counter and sticky overflow/underflow ERR.
module stack_unit
  import stack_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  input  logic [1:0]        REQ_OP,
  input  logic [DATA_W-1:0] REQ_DATA,
  output logic              REQ_READY,
  input  logic              RSP_READY,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic [SP_W-1:0]   SP_OUT,
  output logic              ERR
);
  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_sel_ram_q, rsp_sel_ram_d;

  logic              full, empty;
  logic              ram_we, ram_re;
  logic [SP_W-1:0]   ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    data_d        = data_q;
    sp_d          = sp_q;
    rsp_data_d    = rsp_data_q;
    rsp_sel_ram_d = rsp_sel_ram_q;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    ram_addr      = sp_q;
    ram_wdata     = (op_q == OP_PUSH) ? {2'b00, data_q[7:0]} : data_q;
    case (state_q)
      S_IDLE: if (REQ_VALID) begin
        op_d    = op_e'(REQ_OP);
        data_d  = REQ_DATA;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_RESP;
        if (is_write(op_q)) begin
          rsp_data_d    = ram_wdata;
          rsp_sel_ram_d = 1'b0;
          if (!full) begin
            ram_addr = sp_q - 8'd1;
            ram_we   = !RST;
            sp_d     = sp_q - 8'd1;
          end
        end else if (!empty) begin
          ram_re        = 1'b1;
          sp_d          = sp_q + 8'd1;
          rsp_sel_ram_d = 1'b1;
        end else begin
          rsp_data_d    = '0;
          rsp_sel_ram_d = 1'b0;
        end
      end
      S_RESP: if (RSP_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      op_q          <= OP_PUSH;
      data_q        <= '0;
      sp_q          <= '0;
      rsp_data_q    <= '0;
      rsp_sel_ram_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      data_q        <= data_d;
      sp_q          <= sp_d;
      rsp_data_q    <= rsp_data_d;
      rsp_sel_ram_q <= rsp_sel_ram_d;
    end
  end

`ifdef STACK_GUARD_EN
  logic [SP_W:0] depth_q, depth_d;
  logic          err_q, err_d;

  assign full  = (depth_q == 9'(DEPTH));
  assign empty = (depth_q == '0);
  assign ERR   = err_q;

  always_comb begin
    depth_d = depth_q;
    err_d   = err_q;
    if (state_q == S_EXEC) begin
      if (is_write(op_q)) begin
        if (full) err_d = 1'b1;
        else      depth_d = depth_q + 9'd1;
      end else begin
        if (empty) err_d = 1'b1;
        else       depth_d = depth_q - 9'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end
`else
  assign full  = 1'b0;
  assign empty = 1'b0;
  assign ERR   = 1'b0;
`endif

  stack_ram u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign REQ_READY = (state_q == S_IDLE);
  assign RSP_VALID = (state_q == S_RESP);
  assign RSP_DATA  = rsp_sel_ram_q ? ram_rdata : rsp_data_q;
  assign SP_OUT    = sp_q;
endmodule

// File: tb/tb_stack_unit.sv
// Directed + randomized bench for stack_unit against an array-based stack model.
module tb_stack_unit;
  logic       CLK = 1'b0;
  logic       RST, REQ_VALID, RSP_READY, REQ_READY, RSP_VALID, ERR;
  logic [1:0] REQ_OP;
  logic [9:0] REQ_DATA, RSP_DATA;
  logic [7:0] SP_OUT;

`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  int         n_tests = 0;
  int         n_fail  = 0;
  int         m_sp, m_depth;
  logic       m_err;
  logic [9:0] m_mem   [256];
  bit         m_known [256];

  stack_unit dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_OP(REQ_OP), .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY), .RSP_READY(RSP_READY), .RSP_VALID(RSP_VALID),
    .RSP_DATA(RSP_DATA), .SP_OUT(SP_OUT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sp = 0; m_depth = 0; m_err = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1; REQ_VALID = 1'b0; RSP_READY = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    model_reset();
    check("rst_req_ready", 10'(REQ_READY), 10'd1);
    check("rst_rsp_valid", 10'(RSP_VALID), 10'd0);
    check("rst_rsp_data",  RSP_DATA, 10'd0);
    check("rst_sp",        10'(SP_OUT), 10'd0);
    check("rst_err",       10'(ERR), 10'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_op(input logic [1:0] op, input logic [9:0] d, input int stall);
    logic [9:0] exp_data;
    bit         exp_known;
    check("idle_req_ready", 10'(REQ_READY), 10'd1);
    REQ_VALID = 1'b1; REQ_OP = op; REQ_DATA = d; RSP_READY = 1'b0;
    @(negedge CLK);
    REQ_VALID = 1'($urandom); REQ_OP = 2'($urandom); REQ_DATA = 10'($urandom);
    check("exec_rsp_valid", 10'(RSP_VALID), 10'd0);
    check("exec_req_ready", 10'(REQ_READY), 10'd0);
    if (op == 2'b00 || op == 2'b10) begin
      exp_data  = (op == 2'b00) ? {2'b00, d[7:0]} : d;
      exp_known = 1'b1;
      if (GUARD && m_depth == 256) m_err = 1'b1;
      else begin
        m_sp = (m_sp + 255) % 256;
        m_mem[m_sp] = exp_data; m_known[m_sp] = 1'b1;
        m_depth++;
      end
    end else begin
      if (GUARD && m_depth == 0) begin
        m_err = 1'b1; exp_data = 10'd0; exp_known = 1'b1;
      end else begin
        exp_data = m_mem[m_sp]; exp_known = m_known[m_sp];
        m_sp = (m_sp + 1) % 256;
        m_depth--;
      end
    end
    @(negedge CLK);
    for (int i = 0; i <= stall; i++) begin
      check("resp_valid", 10'(RSP_VALID), 10'd1);
      if (exp_known) check("resp_data", RSP_DATA, exp_data);
      check("resp_sp", 10'(SP_OUT), 10'(m_sp));
      check("resp_err", 10'(ERR), 10'(m_err));
      check("resp_req_ready", 10'(REQ_READY), 10'd0);
      if (i < stall) begin
        REQ_VALID = 1'b1;
        @(negedge CLK);
      end
    end
    // Hold a request on the completing edge: it must not be taken.
    RSP_READY = 1'b1; REQ_VALID = 1'b1; REQ_OP = 2'($urandom); REQ_DATA = 10'($urandom);
    @(negedge CLK);
    RSP_READY = 1'b0; REQ_VALID = 1'b0;
    check("done_rsp_valid", 10'(RSP_VALID), 10'd0);
    check("done_req_ready", 10'(REQ_READY), 10'd1);
    check("done_sp", 10'(SP_OUT), 10'(m_sp));
  endtask

  initial begin
    logic [9:0] rd;
    RST = 1'b1; REQ_VALID = 1'b0; REQ_OP = 2'b00; REQ_DATA = '0; RSP_READY = 1'b0;
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;

    do_reset();
    do_op(2'b00, 10'h0A5, 0);
    do_op(2'b10, 10'h3C2, 0);
    do_op(2'b11, 10'h000, 0);
    do_op(2'b01, 10'h000, 1);
    do_op(2'b00, 10'h311, 0);
    do_op(2'b00, 10'h022, 2);
    do_op(2'b00, 10'h233, 0);
    do_op(2'b01, 10'h000, 5);
    do_op(2'b01, 10'h000, 0);
    do_op(2'b01, 10'h000, 0);
    check("stack_sp_home", 10'(SP_OUT), 10'd0);

    // Pop from empty: underflow with the guard, wrap to 0x01 without.
    do_reset();
    do_op(2'b01, 10'h000, 0);

    // Reset during EXEC of a push must not write mem[0xFF].
    do_reset();
    do_op(2'b00, 10'h0A5, 0);
    do_op(2'b01, 10'h000, 0);
    REQ_VALID = 1'b1; REQ_OP = 2'b00; REQ_DATA = 10'h055;
    @(negedge CLK);
    RST = 1'b1; REQ_VALID = 1'b0;
    @(negedge CLK);
    check("abort_rsp_valid", 10'(RSP_VALID), 10'd0);
    check("abort_sp", 10'(SP_OUT), 10'd0);
    RST = 1'b0;
    model_reset();
    @(negedge CLK);
    check("abort_no_resp", 10'(RSP_VALID), 10'd0);
    check("abort_req_ready", 10'(REQ_READY), 10'd1);
    if (!GUARD) begin
      for (int i = 0; i < 256; i++) do_op(2'b01, 10'h000, 0);
    end

    // Fill past capacity with CALLs, then check the top of stack.
    do_reset();
    for (int i = 0; i < 257; i++) begin
      rd = 10'($urandom);
      do_op(2'b10, rd, 0);
    end
    check("fill_err", 10'(ERR), 10'(GUARD));
    do_op(2'b11, 10'h000, 0);

    // Randomized mix.
    do_reset();
    for (int i = 0; i < 150; i++)
      do_op(2'($urandom), 10'($urandom), int'($urandom_range(0, 2)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
